seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle logical shifter for the 16-bit ALU datapath.
- Shifts one bit position per clock. This iterates the single-bit left/right shift stages to cover arbitrary distances of 0..15.
- Valid/ready handshake on the operand side and on the result side, so the ALU controller can issue a shift and stall until the result is ready.
- Also produces a carry-out (last bit shifted out) and a zero flag for the status register.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SHAMT_W, 4, shift-amount width. Must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  operand, amount and direction are valid.
- in_ready  output  1  unit can accept a new operation.
- inA  input  WIDTH  operand to shift.
- shamt  input  SHAMT_W  shift distance, 0..WIDTH-1.
- dir  input  1  0 = shift left, 1 = shift right.
- arith  input  1  arithmetic right-shift request. Only honoured under ARITH_SHIFT_EN.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- outA  output  WIDTH  shifted result.
- carry  output  1  last bit shifted out. 0 when shamt = 0.
- zero  output  1  1 when outA == 0.

Behaviour:
- Reset: takes effect on any clock edge with rst = 1, from any state, including mid-shift.
  - State returns to IDLE and the in-flight operation is discarded (no result is produced).
  - in_ready = 1 in the cycle after the reset edge.
  - out_valid = 0, outA = 0, carry = 0, zero = 1.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SHIFT: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept: an edge in IDLE with in_valid = 1.
  - Latches inA into the shift register, shamt into the counter, and dir/arith into mode registers.
  - Clears carry.
  - Next state is SHIFT if shamt != 0, else DONE.
- SHIFT, each edge:
  - Left shift: reg <= {reg[WIDTH-2:0], 0} and carry <= reg[WIDTH-1].
  - Right shift: reg <= {fill, reg[WIDTH-1:1]} and carry <= reg[0].
  - fill = 0, except as defined under Optional Feature.
  - Counter decrements by 1. When the counter equals 1 on that edge, next state is DONE.
- Latency: out_valid is first high exactly shamt+1 cycles after the accept cycle (1 cycle for shamt = 0, 16 cycles for shamt = 15).
- DONE:
  - outA, carry and zero stay stable while out_valid = 1 and out_ready = 0. Hold is unbounded.
  - Edge with out_ready = 1: go to IDLE. outA, carry and zero keep their values until the next accept.
  - No new accept in the same cycle as the result handoff (in_ready = 0 in DONE), so there is one idle cycle between operations.
- Inputs inA, shamt, dir and arith are ignored outside the accept edge. Changing them mid-operation has no effect.
- in_valid in SHIFT or DONE: ignored. The producer must hold it until in_ready.
- zero is registered and computed from the next-state shift-register value, so it is never one cycle stale relative to outA.
- The counter never underflows. shamt = 0 bypasses SHIFT entirely.

Optional Feature:
- Macro: ARITH_SHIFT_EN.
- Defined: right shifts with arith = 1 use fill = reg[WIDTH-1], i.e. the sign bit is replicated. Left shifts ignore arith.
- Undefined: the arith port is still present but ignored. All right shifts zero-fill.

Test Plan:
- Reset, then rst = 0 → in_ready = 1, out_valid = 0, outA = 0x0000, zero = 1. Then rst = 1 asserted in SHIFT for dir=0, shamt=8 → IDLE next cycle, no out_valid.
- inA = 0x0001, dir = 0, shamt = 15 → out_valid rises 16 cycles after accept, outA = 0x8000, carry = 0, zero = 0.
- inA = 0x8001, dir = 1, shamt = 1 → out_valid after 2 cycles, outA = 0x4000, carry = 1. Then shamt = 0 with inA = 0x1234 → outA = 0x1234 after 1 cycle, carry = 0.
- inA = 0x00F0, dir = 0, shamt = 12, with out_ready held 0 for 5 cycles in DONE → outA = 0x0000, carry = 1, zero = 1 held stable; returns to IDLE on the first cycle out_ready = 1.
- With ARITH_SHIFT_EN: inA = 0x8000, dir = 1, arith = 1, shamt = 4 → outA = 0xF800. Without the macro → 0x0800.
- Back-to-back: in_valid held high for two operations → second accept occurs only after the DONE→IDLE handoff. inA toggled during SHIFT → result unaffected.

Source files
------------

// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if: operand/result handshake bundle for the multi-cycle shifter
interface seq_shift_unit_if #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   inA;
   logic [SHAMT_W-1:0] shamt;
   logic               dir;
   logic               arith;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   outA;
   logic               carry;
   logic               zero;

   modport master (
      output in_valid, inA, shamt, dir, arith, out_ready,
      input  in_ready, out_valid, outA, carry, zero
   );

   modport slave (
      input  in_valid, inA, shamt, dir, arith, out_ready,
      output in_ready, out_valid, outA, carry, zero
   );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: one-bit-per-clock logical shifter with carry/zero flags; ARITH_SHIFT_EN enables sign-filling right shifts
module seq_shift_unit #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input logic clk,
   input logic rst,
   seq_shift_unit_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
`ifdef ARITH_SHIFT_EN
   localparam logic arithEn = 1'b1;
`else
   localparam logic arithEn = 1'b0;
`endif

   logic [1:0]         state;
   logic [WIDTH-1:0]   shiftReg;
   logic [WIDTH-1:0]   nextReg;
   logic [SHAMT_W-1:0] cnt;
   logic               modeDir;
   logic               modeArith;
   logic               carryReg;
   logic               nextCarry;
   logic               zeroReg;
   logic               fill;

   // single-bit shift stage applied once per SHIFT cycle
   always_comb begin
      fill      = arithEn & modeArith & shiftReg[WIDTH-1];
      nextReg   = modeDir ? {fill, shiftReg[WIDTH-1:1]} : {shiftReg[WIDTH-2:0], 1'b0};
      nextCarry = modeDir ? shiftReg[0] : shiftReg[WIDTH-1];
   end

   // operation sequencer: accept, iterate the shift, hold the result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shiftReg  <= '0;
         cnt       <= '0;
         modeDir   <= 1'b0;
         modeArith <= 1'b0;
         carryReg  <= 1'b0;
         zeroReg   <= 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               shiftReg  <= bus.inA;
               cnt       <= bus.shamt;
               modeDir   <= bus.dir;
               modeArith <= bus.arith;
               carryReg  <= 1'b0;
               zeroReg   <= bus.inA == '0;
               state     <= (bus.shamt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
               shiftReg <= nextReg;
               carryReg <= nextCarry;
               zeroReg  <= nextReg == '0;
               cnt      <= cnt - 1'b1;
               if (cnt == SHAMT_W'(1)) state <= DONE;
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.outA      = shiftReg;
   assign bus.carry     = carryReg;
   assign bus.zero      = zeroReg;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed and randomized checks of seq_shift_unit against an arithmetic reference model
module tb_seq_shift_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   seq_shift_unit_if #(.WIDTH(16), .SHAMT_W(4)) bus ();
   seq_shift_unit #(.WIDTH(16), .SHAMT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void refShift(input logic [15:0] a, input int s, input logic d, input logic ar,
                                    output logic [15:0] r, output logic c);
      int v;
      bit useArith;
`ifdef ARITH_SHIFT_EN
      useArith = d && ar;
`else
      useArith = 1'b0;
`endif
      v = useArith ? int'($signed(a)) : int'({16'b0, a});
      if (s == 0) begin
         r = a;
         c = 1'b0;
      end else if (!d) begin
         r = 16'(v << s);
         c = v[16 - s];
      end else begin
         r = 16'(v >>> s);
         c = v[s - 1];
      end
   endfunction

   task automatic doOp(input logic [15:0] a, input logic [3:0] s, input logic d, input logic ar,
                       input int hold, input bit holdValid);
      logic [15:0] er;
      logic        ec;
      int          w;
      int          lat;
      refShift(a, int'(s), d, ar, er, ec);
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.inA       = a;
      bus.shamt     = s;
      bus.dir       = d;
      bus.arith     = ar;
      bus.out_ready = 1'b0;
      @(negedge clk);
      if (!holdValid) begin
         bus.in_valid = 1'b0;
         bus.inA      = 16'($urandom);
         bus.shamt    = 4'($urandom);
         bus.dir      = 1'($urandom);
         bus.arith    = 1'($urandom);
      end
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         if (!holdValid) bus.inA = 16'($urandom);
         lat++;
      end
      check("latency", 32'(lat), 32'(s) + 32'd1);
      check("outA", 32'(bus.outA), 32'(er));
      check("carry", 32'(bus.carry), 32'(ec));
      check("zero", 32'(bus.zero), 32'(er == 16'h0));
      check("busy_in_done", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_outA", 32'(bus.outA), 32'(er));
         check("hold_flags", {30'b0, bus.carry, bus.zero}, {30'b0, ec, er == 16'h0});
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("handoff_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
      check("after_outA", 32'(bus.outA), 32'(er));
      check("after_carry", 32'(bus.carry), 32'(ec));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.inA       = 16'h0;
      bus.shamt     = 4'h0;
      bus.dir       = 1'b0;
      bus.arith     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_state", {27'b0, bus.in_ready, bus.out_valid, bus.carry, bus.zero, 1'b0}, 32'b10010);
      check("reset_outA", 32'(bus.outA), 32'h0);
      bus.in_valid = 1'b1;
      bus.inA      = 16'h00FF;
      bus.shamt    = 4'd8;
      bus.dir      = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_shift_busy", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_state", {28'b0, bus.in_ready, bus.out_valid, bus.carry, bus.zero}, 32'b1001);
      check("midreset_outA", 32'(bus.outA), 32'h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("midreset_no_result", 32'(bus.out_valid), 32'd0);
      end
      doOp(16'h0001, 4'd15, 1'b0, 1'b0, 0, 1'b0);
      doOp(16'h8001, 4'd1, 1'b1, 1'b0, 0, 1'b0);
      doOp(16'h1234, 4'd0, 1'b0, 1'b0, 0, 1'b0);
      doOp(16'h00F0, 4'd12, 1'b0, 1'b0, 5, 1'b0);
      doOp(16'h8000, 4'd4, 1'b1, 1'b1, 0, 1'b0);
      doOp(16'hA5C3, 4'd7, 1'b1, 1'b0, 1, 1'b1);
      doOp(16'h9001, 4'd3, 1'b1, 1'b1, 0, 1'b1);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 25; i++)
         doOp(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      bus.in_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
